// File: rtl/nand_resp_checker_pkg.sv
// Shared types and helpers for the NAND response checker: FSM state encoding,
// the reference NAND function and default counter sizing.
package nand_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_FINISH
    } chk_state_t;

    localparam int MAX_W     = 64;
    localparam int CNT_W_DEF = 8;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    // Callers size-cast in and out; MAX_W bounds the supported vector width.
    function automatic logic [MAX_W-1:0] exp_nand(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_resp_checker_if.sv
// Stimulus/response link between the vector generator (master) and the
// checker (slave): applied vector with valid/ready, plus the observed gate output.
interface nand_resp_checker_if #(
    parameter int W = 1
);
    logic         vec_valid;
    logic         vec_ready;
    logic [W-1:0] vec_a;
    logic [W-1:0] vec_b;
    logic [W-1:0] obs_c;

    modport master (
        output vec_valid, vec_a, vec_b, obs_c,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, vec_a, vec_b, obs_c,
        output vec_ready
    );
endinterface

// File: rtl/nand_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping so long runs never report a misleadingly small count.
module chk_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/nand_resp_checker.sv
// Observing end of the NAND stimulus/response link: accepts vectors, waits
// SETTLE cycles, compares obs_c to ~(a&b) and keeps pass/fail statistics.
module nand_resp_checker
    import nand_chk_pkg::*;
#(
    parameter int W      = 1,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SETTLE = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_vectors,
    nand_resp_checker_if.slave  vif,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic [3*W-1:0]      first_fail_vec
);
    localparam int              SC_W   = $clog2(SETTLE + 1);
    localparam logic [SC_W-1:0] SC_END = SC_W'(SETTLE);

    chk_state_t       r_state;
    chk_state_t       w_next;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic [SC_W-1:0]  r_settle;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_ff_flag;
    logic [CNT_W-1:0] r_ff_idx;
    logic [3*W-1:0]   r_ff_vec;
    logic             r_pass;

    logic             w_ready;
    logic             w_clr;
    logic             w_accept;
    logic             w_cmp;
    logic             w_inc_pass;
    logic             w_inc_fail;
    logic [W-1:0]     w_exp;
    logic [CNT_W-1:0] w_idx_nxt;

    assign w_exp     = W'(exp_nand(MAX_W'(r_a), MAX_W'(r_b)));
    assign w_idx_nxt = r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An X on obs_c fails the equality test and lands in the mismatch branch.
    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_clr      = 1'b0;
        w_accept   = 1'b0;
        w_cmp      = 1'b0;
        w_inc_pass = 1'b0;
        w_inc_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = (num_vectors == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                w_ready = 1'b1;
                if (vif.vec_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle == SC_END) begin
                    w_cmp = 1'b1;
                    if (vif.obs_c == w_exp) begin
                        w_inc_pass = 1'b1;
                    end else begin
                        w_inc_fail = 1'b1;
                    end
                    w_next = (w_idx_nxt == r_num) ? S_FINISH : S_RUN;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_settle <= '0;
        end else begin
            if (w_clr) begin
                r_num <= num_vectors;
            end
            if (w_accept) begin
                r_a      <= vif.vec_a;
                r_b      <= vif.vec_b;
                r_settle <= SC_W'(1);
            end else if ((r_state == S_SETTLE) && !w_cmp) begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    // Only the first mismatch of a run is captured; later ones just count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_ff_flag <= 1'b0;
            r_ff_idx  <= '0;
            r_ff_vec  <= '0;
        end else if (w_clr) begin
            r_idx     <= '0;
            r_ff_flag <= 1'b0;
            r_ff_idx  <= '0;
            r_ff_vec  <= '0;
        end else if (w_cmp) begin
            r_idx <= w_idx_nxt;
            if (w_inc_fail && !r_ff_flag) begin
                r_ff_flag <= 1'b1;
                r_ff_idx  <= r_idx;
                r_ff_vec  <= {r_a, r_b, vif.obs_c};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (w_clr) begin
            r_pass <= 1'b0;
        end else if (r_state == S_FINISH) begin
            r_pass <= (fail_count == '0);
        end
    end

    chk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_inc (w_inc_pass),
        .o_cnt (pass_count)
    );

    chk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_inc (w_inc_fail),
        .o_cnt (fail_count)
    );

    assign vif.vec_ready  = w_ready;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);
    assign pass           = r_pass;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_nand_resp_checker.sv
// Bench for nand_resp_checker: two instances (W=1/CNT_W=8/SETTLE=5 and
// W=4/CNT_W=2/SETTLE=2) driven by directed and random runs against a run-level model.
module tb_nand_resp_checker;

    localparam int S0 = 5;
    localparam int S1 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start_s [2];
    logic [7:0] num_s   [2];
    logic       valid_s [2];
    logic [3:0] a_s     [2];
    logic [3:0] b_s     [2];
    logic [3:0] c_s     [2];

    logic        rdy_s  [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic        pass_s [2];
    logic [7:0]  pc_s   [2];
    logic [7:0]  fc_s   [2];
    logic [7:0]  fi_s   [2];
    logic [11:0] fv_s   [2];

    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] pc0, fc0, fi0;
    logic [1:0] pc1, fc1, fi1;
    logic [2:0] fv0;
    logic [11:0] fv1;

    nand_resp_checker_if #(.W(1)) if0 ();
    nand_resp_checker_if #(.W(4)) if1 ();

    assign if0.vec_valid = valid_s[0];
    assign if0.vec_a     = a_s[0][0];
    assign if0.vec_b     = b_s[0][0];
    assign if0.obs_c     = c_s[0][0];
    assign if1.vec_valid = valid_s[1];
    assign if1.vec_a     = a_s[1];
    assign if1.vec_b     = b_s[1];
    assign if1.obs_c     = c_s[1];

    nand_resp_checker #(.W(1), .CNT_W(8), .SETTLE(S0)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_s[0]),
        .num_vectors    (num_s[0]),
        .vif            (if0),
        .busy           (busy0),
        .done           (done0),
        .pass           (pass0),
        .pass_count     (pc0),
        .fail_count     (fc0),
        .first_fail_idx (fi0),
        .first_fail_vec (fv0)
    );

    nand_resp_checker #(.W(4), .CNT_W(2), .SETTLE(S1)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_s[1]),
        .num_vectors    (num_s[1][1:0]),
        .vif            (if1),
        .busy           (busy1),
        .done           (done1),
        .pass           (pass1),
        .pass_count     (pc1),
        .fail_count     (fc1),
        .first_fail_idx (fi1),
        .first_fail_vec (fv1)
    );

    assign rdy_s[0]  = if0.vec_ready;
    assign rdy_s[1]  = if1.vec_ready;
    assign busy_s[0] = busy0;
    assign busy_s[1] = busy1;
    assign done_s[0] = done0;
    assign done_s[1] = done1;
    assign pass_s[0] = pass0;
    assign pass_s[1] = pass1;
    assign pc_s[0]   = pc0;
    assign pc_s[1]   = {6'd0, pc1};
    assign fc_s[0]   = fc0;
    assign fc_s[1]   = {6'd0, fc1};
    assign fi_s[0]   = fi0;
    assign fi_s[1]   = {6'd0, fi1};
    assign fv_s[0]   = {9'd0, fv0};
    assign fv_s[1]   = fv1;

    // Cycle bookkeeping sampled at the rising edge (pre-edge output values).
    int cyc         = 0;
    int done_cnt[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int rdy_cnt[2]  = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (done_s[d]) begin
                done_cnt[d] <= done_cnt[d] + 1;
                done_cyc[d] <= cyc;
            end
            if (rdy_s[d]) rdy_cnt[d] <= rdy_cnt[d] + 1;
        end
        cyc <= cyc + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, "_busy"},  busy_s[d], 0);
        chk({tag, "_ready"}, rdy_s[d],  0);
        chk({tag, "_done"},  done_s[d], 0);
        chk({tag, "_pass"},  pass_s[d], 0);
        chk({tag, "_pc"},    pc_s[d],   0);
        chk({tag, "_fc"},    fc_s[d],   0);
        chk({tag, "_fi"},    fi_s[d],   0);
        chk({tag, "_fv"},    fv_s[d],   0);
    endtask

    task automatic pulse_start(input int d, input int n);
        @(negedge clk);
        start_s[d] = 1'b1;
        num_s[d]   = 8'(n);
        @(negedge clk);
        start_s[d] = 1'b0;
        num_s[d]   = 8'($urandom);
    endtask

    // Presents one vector as soon as ready is seen; hs is the handshake cycle.
    task automatic send_vec(input int d, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input int lowc, input bit glitch,
                            output int hs);
        int         t;
        int         s;
        logic [3:0] mask;
        t    = 0;
        s    = (d == 0) ? S0 : S1;
        mask = (d == 0) ? 4'h1 : 4'hF;
        @(negedge clk);
        if (lowc > 0) begin
            valid_s[d] = 1'b0;
            repeat (lowc) @(negedge clk);
            chk("valid_low_ready_held", rdy_s[d], 1);
            chk("valid_low_busy", busy_s[d], 1);
        end
        while (!rdy_s[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", rdy_s[d], 1);
        valid_s[d] = 1'b1;
        a_s[d]     = a;
        b_s[d]     = b;
        c_s[d]     = c;
        hs         = cyc;
        @(posedge clk);
        #1;
        valid_s[d] = 1'b0;
        a_s[d]     = 4'($urandom);
        b_s[d]     = 4'($urandom);
        if (glitch) begin
            for (int i = 0; i < s - 1; i++) begin
                @(negedge clk);
                c_s[d] = ~c & mask;
            end
            @(negedge clk);
            c_s[d] = c;
        end
    endtask

    // mode: 0 correct gate, 1 stuck-at-0, 2 random faults, 3 inverted output.
    task automatic run(input int d, input int n, input int mode, input bit directed,
                       input int lowc, input bit glitch, input bit restart_mid);
        int          cmax, s, ep, ef, eidx, hs, hs0, dc0, t;
        logic [3:0]  mask, a, b, c, nd;
        logic [11:0] evec;
        bit          ff;
        mask = (d == 0) ? 4'h1 : 4'hF;
        cmax = (d == 0) ? 255 : 3;
        s    = (d == 0) ? S0 : S1;
        ep = 0; ef = 0; eidx = 0; evec = '0; ff = 0; hs0 = 0; t = 0;
        dc0 = done_cnt[d];
        pulse_start(d, n);
        for (int i = 0; i < n; i++) begin
            if (directed) begin
                a = 4'((i >> 1) & 1);
                b = 4'(i & 1);
            end else begin
                a = 4'($urandom) & mask;
                b = 4'($urandom) & mask;
            end
            nd = ~(a & b) & mask;
            case (mode)
                0:       c = nd;
                1:       c = 4'h0;
                2:       c = ($urandom_range(0, 2) == 0) ? (nd ^ 4'($urandom_range(1, int'(mask)))) : nd;
                default: c = ~nd & mask;
            endcase
            if (c == nd) begin
                ep = (ep < cmax) ? ep + 1 : cmax;
            end else begin
                ef = (ef < cmax) ? ef + 1 : cmax;
                if (!ff) begin
                    ff   = 1;
                    eidx = i;
                    evec = (d == 0) ? {9'd0, a[0], b[0], c[0]} : {a, b, c};
                end
            end
            send_vec(d, a, b, c, (i == 0) ? lowc : 0, glitch, hs);
            if (i == 0) hs0 = hs;
            if (restart_mid && i == 0) begin
                @(negedge clk);
                start_s[d] = 1'b1;
                num_s[d]   = 8'd1;
                @(negedge clk);
                start_s[d] = 1'b0;
            end
        end
        while (done_cnt[d] == dc0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt[d] - dc0, 1);
        // Span from handshake cycle to done cycle, both inclusive.
        chk("done_latency", done_cyc[d] - hs0 + 1, n * (s + 1) + 1);
        chk("pass_count", pc_s[d], ep);
        chk("fail_count", fc_s[d], ef);
        chk("pass_flag", pass_s[d], (ef == 0) ? 1 : 0);
        chk("first_fail_idx", fi_s[d], eidx);
        chk("first_fail_vec", fv_s[d], evec);
        chk("busy_after", busy_s[d], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, dc0, r0, c0, pc_before;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            num_s[d]   = 8'd0;
            valid_s[d] = 1'b0;
            a_s[d]     = 4'd0;
            b_s[d]     = 4'd0;
            c_s[d]     = 4'd0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero(0, "reset0");
        chk_idle_zero(1, "reset1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 4, 0, 1'b1, 0, 1'b0, 1'b0);
        run(0, 4, 1, 1'b1, 0, 1'b0, 1'b0);

        // Empty run: finishes immediately, never offers ready.
        dc0 = done_cnt[0];
        r0  = rdy_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b1;
        num_s[0]   = 8'd0;
        c0         = cyc;
        @(negedge clk);
        start_s[0] = 1'b0;
        num_s[0]   = 8'd7;
        repeat (3) @(negedge clk);
        chk("empty_done_once", done_cnt[0] - dc0, 1);
        chk("empty_done_latency", done_cyc[0] - c0, 1);
        chk("empty_no_ready", rdy_cnt[0] - r0, 0);
        chk("empty_pass", pass_s[0], 1);
        chk("empty_pc", pc_s[0], 0);
        chk("empty_fc", fc_s[0], 0);

        run(0, 1, 0, 1'b0, 10, 1'b1, 1'b0);

        // Abort mid-run with reset after the second vector is accepted.
        dc0 = done_cnt[0];
        pulse_start(0, 4);
        send_vec(0, 4'd0, 4'd1, 4'd1, 0, 1'b0, hs);
        send_vec(0, 4'd1, 4'd1, 4'd0, 0, 1'b0, hs);
        pc_before = pc_s[0];
        chk("pre_reset_pc", pc_before, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_zero(0, "async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("reset_no_done", done_cnt[0] - dc0, 0);
        chk("reset_idle", busy_s[0], 0);
        run(0, 4, 2, 1'b0, 0, 1'b0, 1'b0);

        run(1, 3, 3, 1'b0, 0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) run(0, $urandom_range(1, 6), 2, 1'b0, 0, 1'b0, 1'b0);
            else            run(1, $urandom_range(1, 3), 2, 1'b0, 0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nand_resp_checker.md
Name: nand_resp_checker

Overview:
- Synthesizable self-checking response block: the observing end of the gate stimulus/response interface.
- Accepts each applied input vector (a, b) through a valid/ready handshake, waits a programmable settle time, samples the gate output c, and compares it against the expected bitwise NAND.
- Accumulates pass/fail counts and captures the first failing vector.
- Sits beside the gate under test, fed by the stimulus generator, for on-chip or bench-level checking.

Parameters:
- W, 1: width of the a, b and c vectors; the comparison is bitwise.
- CNT_W, 8: width of the vector-count, pass-count and fail-count registers.
- SETTLE, 5: cycles between vector acceptance and c sampling; legal range is 1 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE.
- num_vectors  in  CNT_W  number of vectors in the run; latched on start.
- vec_valid  in  1  stimulus vector is presented.
- vec_ready  out  1  checker can accept a vector.
- vec_a  in  W  applied input a.
- vec_b  in  W  applied input b.
- obs_c  in  W  observed gate output.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the run completes.
- pass  out  1  high when the last run had fail_count equal to 0; held until the next start.
- pass_count  out  CNT_W  count of matching vectors.
- fail_count  out  CNT_W  count of mismatching vectors.
- first_fail_idx  out  CNT_W  0-based index of the first failing vector.
- first_fail_vec  out  3*W  {a, b, observed c} of the first failure.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE.
  - vec_ready, busy, done and pass go to 0.
  - All counters and capture registers go to 0.
  - Asserting reset mid-run aborts the run immediately; no done pulse is produced.
- FSM states: IDLE, RUN, SETTLE, FINISH.
- IDLE, on start=1:
  - Latch num_vectors.
  - Clear pass_count, fail_count, first_fail_idx, first_fail_vec, the internal index and the first-fail flag.
  - Clear pass.
  - If num_vectors=0, go to FINISH; otherwise go to RUN.
- RUN:
  - vec_ready=1.
  - On vec_valid&vec_ready at edge k: latch a and b, load the settle counter with 1, go to SETTLE.
- SETTLE:
  - vec_ready=0.
  - The settle counter increments each cycle.
  - At edge k+SETTLE, sample obs_c and compare it against the expected value ~(a&b) over all W bits.
  - Match: pass_count increments.
  - Mismatch: fail_count increments. If the first-fail flag is clear, record the index and {a, b, obs_c} and set the flag.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - The index increments after the compare.
  - If the new index equals num_vectors, go to FINISH; otherwise go to RUN.
- Throughput is one vector per SETTLE+1 cycles.
- FINISH:
  - done=1 for exactly one cycle.
  - pass is set to (fail_count==0), using the count after the final compare.
  - Go to IDLE.
- Simultaneous events and protocol rules:
  - start outside IDLE is ignored.
  - vec_valid outside RUN is ignored; the vector is not consumed.
  - vec_a, vec_b and num_vectors are latched on their accepting edges; later changes have no effect.
  - obs_c is sampled only at the compare edge.
  - Status outputs hold their values in IDLE until the next start.
- X on obs_c at the compare edge counts as a mismatch. This is a bench-only rule; synthesis treats obs_c as ordinary logic.

Decomposition:
- Shared package nand_chk_pkg contains:
  - state enum chk_state_t: IDLE, RUN, SETTLE, FINISH.
  - function exp_nand(a, b) returning ~(a&b).
  - localparam CNT_MAX.
- Sub-module: chk_sat_counter (CNT_W-wide saturating incrementer with synchronous clear), instantiated once for pass_count and once for fail_count.
- The top level holds the FSM, settle counter, index and capture registers.

Test Plan:
- W=1, SETTLE=5, num_vectors=4; apply (0,0),(0,1),(1,0),(1,1) to a correct NAND model.
  - Required: pass_count=4, fail_count=0, pass=1.
  - done pulses once, 4*6+1 cycles after the first accept.
- Same run with a stuck-at-0 output model.
  - Required: pass_count=1, fail_count=3.
  - first_fail_idx=0, first_fail_vec={0,0,0}, pass=0.
- start with num_vectors=0.
  - Required: done pulses one cycle after start; pass=1; both counts 0; vec_ready never asserts.
- Hold vec_valid low for 10 cycles in RUN, then toggle obs_c during SETTLE but correct it before the compare edge.
  - Required: nothing is accepted while vec_valid is low.
  - The vector counts as a pass, because only the compare edge is sampled.
- Drop rst_n for 1 cycle after the 2nd vector of a 4-vector run.
  - Required: all outputs clear asynchronously; no done pulse.
  - A subsequent start runs cleanly from index 0.
- CNT_W=2, num_vectors=3 all failing, plus a repeated start pulse mid-run.
  - Required: fail_count=3, no wrap.
  - The repeated start is ignored; first_fail_idx stays 0.
